// File: rtl/updown_counter_nbit_if.sv
// Control and status bundle for updown_counter_nbit.
// The master drives the level-sampled controls; the counter (slave) returns count and flags.
interface updown_counter_nbit_if #(
    parameter int WIDTH = 8
);
    // No valid/ready handshake: every control is a level sampled on each rising
    // clock edge with priority clr > load > en; status is valid after that edge.
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] Result;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output clr, load, load_val, en, up,
        input  Result, tc, wrap, ovf
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output Result, tc, wrap, ovf
    );
endinterface

// File: rtl/updown_counter_nbit.sv
// Parametrised up/down counter with modulus, load clamp, clear, wrap/saturate mode,
// terminal-count, one-cycle bound pulse and sticky overflow flag.
module updown_counter_nbit #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    updown_counter_nbit_if.slave bus
);
    // One extra bit so MODULUS == 2**WIDTH is representable without truncation.
    localparam longint unsigned MAX_L   = MODULUS - 64'd1;
    localparam logic [WIDTH:0]  MOD_EXT = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]  MAX_EXT = MAX_L[WIDTH:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic [WIDTH:0]   load_ext;
    logic             at_max;
    logic             at_zero;

    always_comb begin
        cnt_ext  = {1'b0, cnt_q};
        inc_ext  = cnt_ext + {{WIDTH{1'b0}}, 1'b1};
        dec_ext  = cnt_ext - {{WIDTH{1'b0}}, 1'b1};
        load_ext = {1'b0, bus.load_val};
        // Incrementing to MODULUS means we sit on the top value; a borrow means we sit on 0.
        at_max   = (inc_ext == MOD_EXT);
        at_zero  = dec_ext[WIDTH];
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (bus.clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            cnt_d = (load_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max) begin
                    cnt_d  = SATURATE ? cnt_q : '0;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    cnt_d  = SATURATE ? cnt_q : MAX_EXT[WIDTH-1:0];
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = dec_ext[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.Result = cnt_q;
    assign bus.tc     = bus.en & (bus.up ? at_max : at_zero);
    assign bus.wrap   = wrap_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_updown_counter_nbit.sv
// Directed bench for updown_counter_nbit across four parameter sets sharing one clock/reset.
module tb_updown_counter_nbit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    updown_counter_nbit_if #(.WIDTH(3)) if_a ();  // W3 M8  wrap
    updown_counter_nbit_if #(.WIDTH(3)) if_b ();  // W3 M6  wrap
    updown_counter_nbit_if #(.WIDTH(4)) if_c ();  // W4 M10 saturate
    updown_counter_nbit_if #(.WIDTH(8)) if_d ();  // W8 M256 wrap

    updown_counter_nbit #(.WIDTH(3), .MODULUS(8),   .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    updown_counter_nbit #(.WIDTH(3), .MODULUS(6),   .SATURATE(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    updown_counter_nbit #(.WIDTH(4), .MODULUS(10),  .SATURATE(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
    updown_counter_nbit #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] zero3;
        zero3 = 3'd0;
        rst = 1'b1;
        #2;
        checks++;
        if (if_a.Result !== zero3 || if_a.wrap !== 1'b0 || if_a.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got Result=%0d wrap=%b ovf=%b exp 0/0/0", if_a.Result, if_a.wrap, if_a.ovf);
        end
        // Counting requested while rst is still high must not step.
        if_a.en = 1'b1;
        if_a.up = 1'b1;
        edge_wait();
        checks++;
        if (if_a.Result !== zero3) begin
            errors++;
            $display("FAIL reset_hold_edge got %0d exp 0", if_a.Result);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_count_up();
        logic [2:0] exp_r;
        logic       exp_tc;
        for (int i = 1; i <= 9; i++) begin
            exp_tc = ((i - 1) % 8 == 7);
            checks++;
            if (if_a.tc !== exp_tc) begin
                errors++;
                $display("FAIL count_tc step %0d got %b exp %b", i, if_a.tc, exp_tc);
            end
            edge_wait();
            exp_r = 3'(i % 8);
            checks++;
            if (if_a.Result !== exp_r || if_a.wrap !== (i == 8) || if_a.ovf !== (i >= 8)) begin
                errors++;
                $display("FAIL count_up step %0d got Result=%0d wrap=%b ovf=%b exp %0d/%b/%b",
                         i, if_a.Result, if_a.wrap, if_a.ovf, exp_r, (i == 8), (i >= 8));
            end
        end
        if_a.en = 1'b0;
    endtask

    task automatic test_modulus_down();
        logic [2:0] exp_seq [4];
        exp_seq = '{3'd1, 3'd0, 3'd5, 3'd4};
        if_b.load_val = 3'd2;
        if_b.load = 1'b1;
        edge_wait();
        if_b.load = 1'b0;
        checks++;
        if (if_b.Result !== 3'd2) begin
            errors++;
            $display("FAIL mod_load got %0d exp 2", if_b.Result);
        end
        if_b.en = 1'b1;
        if_b.up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (if_b.tc !== (i == 2)) begin
                errors++;
                $display("FAIL mod_tc step %0d got %b exp %b", i, if_b.tc, (i == 2));
            end
            edge_wait();
            checks++;
            if (if_b.Result !== exp_seq[i] || if_b.wrap !== (i == 2)) begin
                errors++;
                $display("FAIL mod_down step %0d got Result=%0d wrap=%b exp %0d/%b",
                         i, if_b.Result, if_b.wrap, exp_seq[i], (i == 2));
            end
        end
        if_b.en = 1'b0;
        checks++;
        if (if_b.ovf !== 1'b1) begin
            errors++;
            $display("FAIL mod_ovf got %b exp 1", if_b.ovf);
        end
    endtask

    task automatic test_saturate();
        if_c.load_val = 4'd8;
        if_c.load = 1'b1;
        edge_wait();
        if_c.load = 1'b0;
        if_c.en = 1'b1;
        if_c.up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_wait();
            checks++;
            if (if_c.Result !== 4'd9 || if_c.wrap !== (i >= 1) || if_c.ovf !== (i >= 1)) begin
                errors++;
                $display("FAIL sat_hold step %0d got Result=%0d wrap=%b ovf=%b exp 9/%b/%b",
                         i, if_c.Result, if_c.wrap, if_c.ovf, (i >= 1), (i >= 1));
            end
        end
        if_c.en = 1'b0;
        if_c.clr = 1'b1;
        edge_wait();
        if_c.clr = 1'b0;
        checks++;
        if (if_c.Result !== 4'd0 || if_c.ovf !== 1'b0 || if_c.wrap !== 1'b0) begin
            errors++;
            $display("FAIL sat_clr got Result=%0d ovf=%b wrap=%b exp 0/0/0", if_c.Result, if_c.ovf, if_c.wrap);
        end
    endtask

    task automatic test_load_clamp();
        // if_b carries ovf=1 from the down-wrap; a load must keep it.
        if_b.load_val = 3'd7;
        if_b.load = 1'b1;
        if_b.en = 1'b1;
        if_b.up = 1'b1;
        edge_wait();
        checks++;
        if (if_b.Result !== 3'd5 || if_b.wrap !== 1'b0 || if_b.ovf !== 1'b1) begin
            errors++;
            $display("FAIL clamp got Result=%0d wrap=%b ovf=%b exp 5/0/1", if_b.Result, if_b.wrap, if_b.ovf);
        end
        if_b.clr = 1'b1;
        edge_wait();
        if_b.clr = 1'b0;
        if_b.load = 1'b0;
        if_b.en = 1'b0;
        checks++;
        if (if_b.Result !== 3'd0 || if_b.ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_over_load got Result=%0d ovf=%b exp 0/0", if_b.Result, if_b.ovf);
        end
    endtask

    task automatic test_async_reset();
        // if_a sits at 1 with ovf set; four steps bring it to 5.
        if_a.en = 1'b1;
        if_a.up = 1'b1;
        repeat (4) edge_wait();
        checks++;
        if (if_a.Result !== 3'd5 || if_a.ovf !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got Result=%0d ovf=%b exp 5/1", if_a.Result, if_a.ovf);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (if_a.Result !== 3'd0 || if_a.ovf !== 1'b0 || if_a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got Result=%0d ovf=%b wrap=%b exp 0/0/0", if_a.Result, if_a.ovf, if_a.wrap);
        end
        edge_wait();
        rst = 1'b0;
        edge_wait();
        checks++;
        if (if_a.Result !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_count got %0d exp 1", if_a.Result);
        end
        if_a.en = 1'b0;
    endtask

    task automatic test_full_range();
        if_d.load_val = 8'd255;
        if_d.load = 1'b1;
        edge_wait();
        if_d.load = 1'b0;
        if_d.en = 1'b1;
        if_d.up = 1'b1;
        #1;
        checks++;
        if (if_d.Result !== 8'd255 || if_d.tc !== 1'b1) begin
            errors++;
            $display("FAIL full_pre_up got Result=%0d tc=%b exp 255/1", if_d.Result, if_d.tc);
        end
        edge_wait();
        checks++;
        if (if_d.Result !== 8'd0 || if_d.wrap !== 1'b1 || if_d.ovf !== 1'b1) begin
            errors++;
            $display("FAIL full_up_wrap got Result=%0d wrap=%b ovf=%b exp 0/1/1", if_d.Result, if_d.wrap, if_d.ovf);
        end
        if_d.up = 1'b0;
        #1;
        checks++;
        if (if_d.tc !== 1'b1) begin
            errors++;
            $display("FAIL full_tc_down got %b exp 1", if_d.tc);
        end
        edge_wait();
        checks++;
        if (if_d.Result !== 8'd255 || if_d.wrap !== 1'b1) begin
            errors++;
            $display("FAIL full_down_wrap got Result=%0d wrap=%b exp 255/1", if_d.Result, if_d.wrap);
        end
        if_d.en = 1'b0;
        edge_wait();
        checks++;
        if (if_d.Result !== 8'd255 || if_d.wrap !== 1'b0 || if_d.tc !== 1'b0) begin
            errors++;
            $display("FAIL full_idle got Result=%0d wrap=%b tc=%b exp 255/0/0", if_d.Result, if_d.wrap, if_d.tc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if_a.clr = 1'b0; if_a.load = 1'b0; if_a.load_val = '0; if_a.en = 1'b0; if_a.up = 1'b0;
        if_b.clr = 1'b0; if_b.load = 1'b0; if_b.load_val = '0; if_b.en = 1'b0; if_b.up = 1'b0;
        if_c.clr = 1'b0; if_c.load = 1'b0; if_c.load_val = '0; if_c.en = 1'b0; if_c.up = 1'b0;
        if_d.clr = 1'b0; if_d.load = 1'b0; if_d.load_val = '0; if_d.en = 1'b0; if_d.up = 1'b0;
        test_reset();
        test_count_up();
        test_modulus_down();
        test_saturate();
        test_load_clamp();
        test_async_reset();
        test_full_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
